mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_e          : arbiter FSM state
//   DEFAULT_MAX_D_STREAK : default data-grant streak limit while a fetch waits
//   port_access_t        : one latched access on the shared memory port
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_MAX_D_STREAK = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } port_access_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one registered memory port.
// Data accesses win by default; after MAX_D_STREAK consecutive data grants with
// a fetch waiting, the fetch is granted next.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata fetch requester (level request, pulse ack)
//   d_read/d_write/d_addr/d_wdata/d_be -> d_ack/d_rdata  load/store requester
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be, mem_rdata/mem_ready  memory port
//   stall                             combinational pipeline stall
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall
);

  localparam int unsigned STREAK_W =
    ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state;
  arb_state_e          next_state;
  logic                d_pend;
  logic                grant_d;
  logic                grant_i;
  logic                done_d;
  logic                done_i;
  logic [STREAK_W-1:0] streak;
  port_access_t        acc_q;
  port_access_t        acc_next;

  assign d_pend = d_read | d_write;
  assign stall  = (if_req & ~if_ack) | (d_pend & ~d_ack);

  assign mem_we    = acc_q.we;
  assign mem_addr  = acc_q.addr;
  assign mem_wdata = acc_q.wdata;
  assign mem_be    = acc_q.be;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state. The ack cycle is the mandatory IDLE gap: requesters are still
  // dropping their request there, so no grant is made in it.
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!(if_ack | d_ack)) begin
          if (d_pend && (!if_req || (streak < STREAK_LIMIT))) begin
            grant_d    = 1'b1;
            next_state = SERVE_D;
          end else if (if_req) begin
            grant_i    = 1'b1;
            next_state = SERVE_I;
          end
        end
      end
      SERVE_D, SERVE_I: begin
        if (mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: access fields to latch on a grant, completion strobes.
  always_comb begin
    acc_next = acc_q;
    if (grant_d) begin
      acc_next.addr  = d_addr;
      acc_next.wdata = d_wdata;
      acc_next.we    = d_write;
      acc_next.be    = d_write ? d_be : 4'hF;
    end else if (grant_i) begin
      acc_next.addr  = if_addr;
      acc_next.wdata = '0;
      acc_next.we    = 1'b0;
      acc_next.be    = 4'hF;
    end
    done_d = (state == SERVE_D) && mem_ready;
    done_i = (state == SERVE_I) && mem_ready;
  end

  // Registered memory port, acks, read data and streak counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mem_req  <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      streak   <= '0;
    end else begin
      acc_q   <= acc_next;
      mem_req <= (next_state != IDLE);
      if_ack  <= done_i;
      d_ack   <= done_d;
      if (done_i) if_rdata <= mem_rdata;
      // Stores (including read+write together) leave d_rdata untouched.
      if (done_d && !acc_q.we) d_rdata <= mem_rdata;
      if (grant_i) begin
        streak <= '0;
      end else if (grant_d) begin
        if (!if_req)          streak <= '0;
        else if (streak != '1) streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall(stall)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned mem_wait = 0;
  int unsigned wcnt = 0;
  int unsigned req_cycles = 0;
  int unsigned stab_err = 0;
  bit          d_hold = 1'b0;
  logic        mem_req_q = 1'b0;
  port_access_t last_acc;

  // Observed events (filled by step) and expected events (filled by tests)
  port_access_t gnt_q[$];
  int unsigned  gnt_cyc_q[$];
  logic [32:0]  ack_q[$];
  int unsigned  ack_cyc_q[$];
  port_access_t exp_gnt_q[$];
  logic [32:0]  exp_ack_q[$];
  logic [31:0]  exp_d_rdata = '0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic port_access_t mk_acc(input logic [31:0] a, input logic [31:0] w,
                                          input logic [3:0] be, input logic we);
    port_access_t r;
    r.addr = a; r.wdata = w; r.be = be; r.we = we;
    return r;
  endfunction

  task automatic clear_sb();
    gnt_q.delete(); gnt_cyc_q.delete(); ack_q.delete(); ack_cyc_q.delete();
    exp_gnt_q.delete(); exp_ack_q.delete();
    req_cycles = 0; stab_err = 0;
  endtask

  // Advance to the next falling edge: record DUT events, let requesters drop
  // on ack, and play the memory (ready after mem_wait wait cycles).
  task automatic step();
    port_access_t cur;
    @(negedge clk);
    cyc++;
    cur = mk_acc(mem_addr, mem_wdata, mem_be, mem_we);
    if (mem_req === 1'b1) begin
      req_cycles++;
      if (mem_req_q !== 1'b1) begin
        gnt_q.push_back(cur);
        gnt_cyc_q.push_back(cyc);
      end else if (cur !== last_acc) begin
        stab_err++;
      end
    end
    mem_req_q = mem_req;
    last_acc  = cur;
    if (if_ack === 1'b1) begin
      ack_q.push_back({1'b0, if_rdata});
      ack_cyc_q.push_back(cyc);
      if_req = 1'b0;
    end
    if (d_ack === 1'b1) begin
      ack_q.push_back({1'b1, d_rdata});
      ack_cyc_q.push_back(cyc);
      if (!d_hold) begin d_read = 1'b0; d_write = 1'b0; end
    end
    if (mem_req === 1'b1) begin
      mem_ready = (wcnt == mem_wait);
      wcnt++;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
    mem_rdata = mem_model(mem_addr);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack, if_rdata, d_rdata, stall} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h be=%h if_ack=%b d_ack=%b if_rdata=%h d_rdata=%h stall=%b, expected all zero",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack, if_rdata, d_rdata, stall);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_req: got %b, expected 0", mem_req);
    end
  endtask

  task automatic test_fetch_zero_wait();
    int unsigned k;
    clear_sb(); mem_wait = 0;
    if_addr = 32'h100; if_req = 1'b1; k = cyc;
    exp_gnt_q.push_back(mk_acc(32'h100, 32'h0, 4'hF, 1'b0));
    exp_ack_q.push_back({1'b0, 32'h13});
    repeat (8) step();
    vectors++;
    if (gnt_q.size() != 1 || ack_q.size() != 1) begin
      miscompares++;
      $display("FAIL fetch_counts: got grants=%0d acks=%0d, expected 1 and 1", gnt_q.size(), ack_q.size());
    end
    foreach (exp_gnt_q[i]) begin
      vectors++;
      if (gnt_q[i] !== exp_gnt_q[i]) begin
        miscompares++; $display("FAIL fetch_grant[%0d]: got %h, expected %h", i, gnt_q[i], exp_gnt_q[i]);
      end
    end
    foreach (exp_ack_q[i]) begin
      vectors++;
      if (ack_q[i] !== exp_ack_q[i]) begin
        miscompares++; $display("FAIL fetch_ack[%0d]: got %h, expected %h", i, ack_q[i], exp_ack_q[i]);
      end
    end
    vectors++;
    if (gnt_cyc_q[0] != k + 1) begin
      miscompares++; $display("FAIL fetch_req_latency: got %0d, expected %0d", gnt_cyc_q[0] - k, 1);
    end
    vectors++;
    if (ack_cyc_q[0] != k + 2) begin
      miscompares++; $display("FAIL fetch_ack_latency: got %0d, expected %0d", ack_cyc_q[0] - k, 2);
    end
    vectors++;
    if (if_rdata !== 32'h13) begin
      miscompares++; $display("FAIL fetch_rdata_hold: got %h, expected %h", if_rdata, 32'h13);
    end
  endtask

  task automatic test_arbitration();
    int unsigned k;
    bit seen_if;
    clear_sb(); mem_wait = 0;
    if_addr = 32'h104; if_req = 1'b1;
    d_addr = 32'h2000; d_wdata = 32'h1111_2222; d_be = 4'b0101; d_read = 1'b1; d_write = 1'b0;
    k = cyc;
    exp_gnt_q.push_back(mk_acc(32'h2000, 32'h1111_2222, 4'hF, 1'b0));
    exp_gnt_q.push_back(mk_acc(32'h104, 32'h0, 4'hF, 1'b0));
    exp_ack_q.push_back({1'b1, mem_model(32'h2000)});
    exp_ack_q.push_back({1'b0, mem_model(32'h104)});
    exp_d_rdata = mem_model(32'h2000);
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL stall_on_request: got %b, expected 1", stall);
    end
    seen_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if_ack === 1'b1) seen_if = 1'b1;
      vectors++;
      if (stall !== !seen_if) begin
        miscompares++; $display("FAIL stall_cycle%0d: got %b, expected %b", i + 1, stall, !seen_if);
      end
    end
    vectors++;
    if (gnt_q.size() != 2 || ack_q.size() != 2) begin
      miscompares++;
      $display("FAIL arb_counts: got grants=%0d acks=%0d, expected 2 and 2", gnt_q.size(), ack_q.size());
    end
    foreach (exp_gnt_q[i]) begin
      vectors++;
      if (gnt_q[i] !== exp_gnt_q[i]) begin
        miscompares++; $display("FAIL arb_grant[%0d]: got %h, expected %h", i, gnt_q[i], exp_gnt_q[i]);
      end
    end
    foreach (exp_ack_q[i]) begin
      vectors++;
      if (ack_q[i] !== exp_ack_q[i]) begin
        miscompares++; $display("FAIL arb_ack[%0d]: got %h, expected %h", i, ack_q[i], exp_ack_q[i]);
      end
    end
    vectors++;
    if (gnt_cyc_q[0] != k + 1 || gnt_cyc_q[1] != k + 4 || ack_cyc_q[0] != k + 2 || ack_cyc_q[1] != k + 5) begin
      miscompares++;
      $display("FAIL arb_timing: got grants@+%0d,+%0d acks@+%0d,+%0d, expected +1,+4 +2,+5",
               gnt_cyc_q[0] - k, gnt_cyc_q[1] - k, ack_cyc_q[0] - k, ack_cyc_q[1] - k);
    end
  endtask

  task automatic test_store_wait();
    int unsigned k;
    clear_sb(); mem_wait = 3;
    d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; d_write = 1'b1; d_read = 1'b0;
    k = cyc;
    exp_gnt_q.push_back(mk_acc(32'h2004, 32'hDEAD_BEEF, 4'b0011, 1'b1));
    exp_ack_q.push_back({1'b1, exp_d_rdata});
    repeat (10) step();
    vectors++;
    if (gnt_q.size() != 1 || ack_q.size() != 1) begin
      miscompares++;
      $display("FAIL store_counts: got grants=%0d acks=%0d, expected 1 and 1", gnt_q.size(), ack_q.size());
    end
    vectors++;
    if (gnt_q[0] !== exp_gnt_q[0]) begin
      miscompares++; $display("FAIL store_grant: got %h, expected %h", gnt_q[0], exp_gnt_q[0]);
    end
    vectors++;
    if (ack_q[0] !== exp_ack_q[0]) begin
      miscompares++; $display("FAIL store_ack: got %h, expected %h", ack_q[0], exp_ack_q[0]);
    end
    vectors++;
    if (req_cycles != 4 || stab_err != 0) begin
      miscompares++;
      $display("FAIL store_req_window: got cycles=%0d unstable=%0d, expected 4 and 0", req_cycles, stab_err);
    end
    vectors++;
    if (ack_cyc_q[0] != k + 5) begin
      miscompares++; $display("FAIL store_ack_latency: got %0d, expected 5", ack_cyc_q[0] - k);
    end

    // read and write together behave as a store
    clear_sb(); mem_wait = 0;
    d_addr = 32'h2008; d_wdata = 32'hCAFE_F00D; d_be = 4'b1100; d_read = 1'b1; d_write = 1'b1;
    exp_gnt_q.push_back(mk_acc(32'h2008, 32'hCAFE_F00D, 4'b1100, 1'b1));
    exp_ack_q.push_back({1'b1, exp_d_rdata});
    repeat (6) step();
    vectors++;
    if (gnt_q.size() != 1 || ack_q.size() != 1) begin
      miscompares++;
      $display("FAIL rw_counts: got grants=%0d acks=%0d, expected 1 and 1", gnt_q.size(), ack_q.size());
    end
    vectors++;
    if (gnt_q[0] !== exp_gnt_q[0]) begin
      miscompares++; $display("FAIL rw_grant: got %h, expected %h", gnt_q[0], exp_gnt_q[0]);
    end
    vectors++;
    if (ack_q[0] !== exp_ack_q[0]) begin
      miscompares++; $display("FAIL rw_ack: got %h, expected %h", ack_q[0], exp_ack_q[0]);
    end
  endtask

  task automatic test_streak();
    logic [31:0] exp_addr [5];
    logic [31:0] got_addr [$];
    int unsigned r;
    exp_addr = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h400};
    clear_sb(); mem_wait = 0;
    d_addr = 32'h3000; d_wdata = '0; d_be = 4'hF; d_read = 1'b1; d_write = 1'b0; d_hold = 1'b1;
    if_addr = 32'h400;
    // phase 0: fresh streak; phase 1: after the fetch grant and idle-fetch data grants
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        clear_sb();
        repeat (6) step();
      end
      r = cyc;
      if_req = 1'b1;
      repeat (20) step();
      got_addr.delete();
      foreach (gnt_q[i]) if (gnt_cyc_q[i] > r) got_addr.push_back(gnt_q[i].addr);
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (got_addr[i] !== exp_addr[i]) begin
          miscompares++;
          $display("FAIL streak_p%0d_grant%0d: got addr %h, expected %h", p, i, got_addr[i], exp_addr[i]);
        end
      end
    end
    d_hold = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset_mid();
    clear_sb(); mem_wait = 10;
    d_addr = 32'h2010; d_wdata = '0; d_be = 4'hF; d_read = 1'b1; d_write = 1'b0;
    repeat (3) step();
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_busy: got %b, expected 1", mem_req);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({mem_req, d_ack, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_abort: got req=%b d_ack=%b d_rdata=%h, expected 0 0 0", mem_req, d_ack, d_rdata);
    end
    rst = 1'b0; mem_wait = 0;
    vectors++;
    if (ack_q.size() != 0) begin
      miscompares++; $display("FAIL rst_mid_no_ack: got %0d acks, expected 0", ack_q.size());
    end
    clear_sb();
    exp_gnt_q.push_back(mk_acc(32'h2010, 32'h0, 4'hF, 1'b0));
    exp_ack_q.push_back({1'b1, mem_model(32'h2010)});
    repeat (8) step();
    vectors++;
    if (gnt_q.size() != 1 || ack_q.size() != 1) begin
      miscompares++;
      $display("FAIL rst_regrant_counts: got grants=%0d acks=%0d, expected 1 and 1", gnt_q.size(), ack_q.size());
    end
    vectors++;
    if (gnt_q[0] !== exp_gnt_q[0]) begin
      miscompares++; $display("FAIL rst_regrant: got %h, expected %h", gnt_q[0], exp_gnt_q[0]);
    end
    vectors++;
    if (ack_q[0] !== exp_ack_q[0]) begin
      miscompares++; $display("FAIL rst_reack: got %h, expected %h", ack_q[0], exp_ack_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_arbitration();
    test_store_wait();
    test_streak();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
